// File: rtl/anneal_pkg.sv
// Shared types and default widths for the annealing accept/reject decider.
package anneal_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    DECIDE = 2'd2,
    HOLD   = 2'd3
  } accept_state_t;

  localparam int RAND_W_DEF    = 20;
  localparam int BETA_FRAC_DEF = 8;
  localparam int BETA_W_DEF    = 16;

  typedef logic [BETA_W_DEF-1:0] beta_t;

endpackage

// File: rtl/anneal_schedule.sv
// Cooling schedule: beta register and per-level step counter, advanced by
// output handshakes, reloaded by restart, saturating at BETA_MAX.
module anneal_schedule
  import anneal_pkg::*;
#(
  parameter int BETA_W          = 16,
  parameter int BETA0           = 256,
  parameter int BETA_STEP       = 16,
  parameter int BETA_MAX        = 4096,
  parameter int STEPS_PER_LEVEL = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              restart,
  input  logic              hs,
  output logic [BETA_W-1:0] beta
);

  localparam int CNT_W = (STEPS_PER_LEVEL > 1) ? $clog2(STEPS_PER_LEVEL) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS_PER_LEVEL - 1);

  logic [BETA_W-1:0] beta_q, beta_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BETA_W:0]   beta_sum;

  always_comb begin
    beta_d   = beta_q;
    cnt_d    = cnt_q;
    // One extra bit keeps the increment from wrapping before the clamp.
    beta_sum = {1'b0, beta_q} + (BETA_W+1)'(BETA_STEP);
    if (restart) begin
      beta_d = BETA_W'(BETA0);
      cnt_d  = '0;
    end else if (hs) begin
      if (cnt_q == LAST_STEP) begin
        cnt_d  = '0;
        beta_d = (beta_sum > (BETA_W+1)'(BETA_MAX)) ? BETA_W'(BETA_MAX)
                                                     : beta_sum[BETA_W-1:0];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beta_q <= BETA_W'(BETA0);
      cnt_q  <= '0;
    end else begin
      beta_q <= beta_d;
      cnt_q  <= cnt_d;
    end
  end

  assign beta = beta_q;

endmodule

// File: rtl/anneal_accept_decider.sv
// Accept/reject decider for proposed spike flips using a shift-based Boltzmann
// approximation. Optional ANNEAL_STATS_EN adds accept/reject counters.
module anneal_accept_decider
  import anneal_pkg::*;
#(
  parameter int RAND_W          = RAND_W_DEF,
  parameter int DELTA_W         = 21,
  parameter int BETA_W          = 16,
  parameter int BETA_FRAC       = BETA_FRAC_DEF,
  parameter int BETA0           = 256,
  parameter int BETA_STEP       = 16,
  parameter int BETA_MAX        = 4096,
  parameter int STEPS_PER_LEVEL = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DELTA_W-1:0] delta,
  input  logic [RAND_W-1:0]  rand_in,
  output logic               rand_take,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_accept,
  output logic [BETA_W-1:0]  beta_out
`ifdef ANNEAL_STATS_EN
  ,
  output logic [31:0]        accept_cnt,
  output logic [31:0]        reject_cnt
`endif
);

  localparam int PROD_W = DELTA_W + BETA_W + 1;
  localparam int SH_W   = $clog2(RAND_W + 1);

  accept_state_t              state_q, state_d;
  logic signed [DELTA_W-1:0]  delta_q, delta_d;
  logic signed [PROD_W-1:0]   prod_q, prod_d;
  logic                       accept_q, accept_d;
  logic [BETA_W-1:0]          beta;
  logic signed [PROD_W-1:0]   shift_w;
  logic [RAND_W:0]            thresh;
  logic                       decide_accept;
  logic                       out_hs;

  assign out_hs = (state_q == HOLD) && out_ready;

  anneal_schedule #(
    .BETA_W          (BETA_W),
    .BETA0           (BETA0),
    .BETA_STEP       (BETA_STEP),
    .BETA_MAX        (BETA_MAX),
    .STEPS_PER_LEVEL (STEPS_PER_LEVEL)
  ) u_schedule (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .hs      (out_hs),
    .beta    (beta)
  );

  // Probability 2^-shift is realised as a threshold on the uniform LFSR word.
  always_comb begin
    shift_w       = prod_q >>> BETA_FRAC;
    thresh        = {1'b1, {RAND_W{1'b0}}} >> shift_w[SH_W-1:0];
    decide_accept = 1'b0;
    if (delta_q[DELTA_W-1] || (delta_q == '0)) begin
      decide_accept = 1'b1;
    end else if (shift_w >= $signed(PROD_W'(RAND_W))) begin
      decide_accept = 1'b0;
    end else begin
      decide_accept = ({1'b0, rand_in} < thresh);
    end
  end

  always_comb begin
    state_d  = state_q;
    delta_d  = delta_q;
    prod_d   = prod_q;
    accept_d = accept_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          delta_d = $signed(delta);
          state_d = MUL;
        end
      end
      MUL: begin
        prod_d  = $signed({{(PROD_W-DELTA_W){delta_q[DELTA_W-1]}}, delta_q}) *
                  $signed({{(PROD_W-BETA_W){1'b0}}, beta});
        state_d = DECIDE;
      end
      DECIDE: begin
        accept_d = decide_accept;
        state_d  = HOLD;
      end
      HOLD: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      delta_q  <= '0;
      prod_q   <= '0;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      delta_q  <= delta_d;
      prod_q   <= prod_d;
      accept_q <= accept_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == HOLD);
  assign rand_take  = (state_q == DECIDE);
  assign out_accept = accept_q;
  assign beta_out   = beta;

`ifdef ANNEAL_STATS_EN
  logic [31:0] accept_cnt_q, accept_cnt_d;
  logic [31:0] reject_cnt_q, reject_cnt_d;

  always_comb begin
    accept_cnt_d = accept_cnt_q;
    reject_cnt_d = reject_cnt_q;
    if (restart) begin
      accept_cnt_d = '0;
      reject_cnt_d = '0;
    end else if (out_hs) begin
      if (accept_q) accept_cnt_d = accept_cnt_q + 32'd1;
      else          reject_cnt_d = reject_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      accept_cnt_q <= '0;
      reject_cnt_q <= '0;
    end else begin
      accept_cnt_q <= accept_cnt_d;
      reject_cnt_q <= reject_cnt_d;
    end
  end

  assign accept_cnt = accept_cnt_q;
  assign reject_cnt = reject_cnt_q;
`endif

endmodule

// File: doc/anneal_accept_decider.md
Name: anneal_accept_decider

Overview:
- Consumer end of the `random_lfsr` stream: decides accept/reject for each proposed spike-state flip in the annealing core.
- Takes a signed energy delta, scales it by an internal inverse-temperature (beta), and compares an approximated Boltzmann probability against the sampled LFSR word.
- Owns the cooling schedule. Sits between the energy MAC and the neuron-state update logic.

Parameters:
- RAND_W, 20, width of `rand_in`; must match the `random_lfsr` `out` width.
- DELTA_W, 21, signed energy-delta width.
- BETA_W, 16, unsigned beta width.
- BETA_FRAC, 8, fractional bits of beta.
- BETA0, 256, beta after reset or restart (1.0).
- BETA_STEP, 16, beta increment per level.
- BETA_MAX, 4096, beta saturation value.
- STEPS_PER_LEVEL, 64, decisions per cooling level; must be ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- restart  in  1  synchronous pulse; reloads the schedule
- in_valid  in  1  delta request valid
- in_ready  out  1  decider can take a delta
- delta  in  DELTA_W  signed energy change of the proposed flip
- rand_in  in  RAND_W  free-running LFSR value
- rand_take  out  1  pulse: `rand_in` sampled this cycle
- out_valid  out  1  decision valid
- out_ready  in  1  downstream takes the decision
- out_accept  out  1  1 = accept flip
- beta_out  out  BETA_W  current beta

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - FSM to IDLE
  - in_ready=1, out_valid=0, out_accept=0, rand_take=0
  - beta=BETA0, step counter=0
- FSM states: IDLE → MUL → DECIDE → HOLD → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, register `delta` and go to MUL.
- MUL:
  - in_ready=0.
  - Register `prod = delta * $signed({1'b0,beta})`, width DELTA_W+BETA_W+1, full precision, no truncation.
  - Go to DECIDE.
- DECIDE, with `shift = prod >>> BETA_FRAC` (arithmetic shift):
  - If delta ≤ 0: accept.
  - Else if shift ≥ RAND_W: reject.
  - Else: accept iff rand_in < (2^RAND_W >> shift), compared unsigned at RAND_W+1 bits. shift=0 therefore always accepts.
  - rand_take=1 for exactly this cycle, whatever the delta sign.
  - Register out_accept, set out_valid=1, go to HOLD.
- HOLD:
  - out_valid and out_accept stay stable until out_ready=1.
  - On handshake: out_valid←0, go to IDLE.
  - The next in_ready=1 comes one cycle later, so throughput is at most one decision per 4 cycles.
- Latency: input handshake at cycle N gives out_valid=1 at cycle N+3.
- Cooling schedule:
  - The step counter increments on each output handshake.
  - When it reaches STEPS_PER_LEVEL−1 and a handshake occurs, the counter goes to 0 and beta←min(beta+BETA_STEP, BETA_MAX). The addition is done at BETA_W+1 bits so it cannot wrap.
  - beta updates only at output handshakes, so it is never changed mid-decision.
- restart:
  - Sets beta=BETA0 and counter=0 on the next edge.
  - If restart coincides with an output handshake, restart wins.
  - Restart does not abort an in-flight decision; that decision keeps the beta it latched in MUL.
- Reset mid-operation discards any in-flight delta or decision; no output handshake is produced for it.
- `beta_out` shows the registered beta at all times.

Optional Feature:
- Macro: ANNEAL_STATS_EN.
- Defined:
  - Adds outputs `accept_cnt[31:0]` and `reject_cnt[31:0]`.
  - Each increments on the output handshake according to out_accept; both wrap modulo 2^32.
  - Both clear on rst or restart.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package `anneal_pkg`:
  - FSM enum `accept_state_t` {IDLE, MUL, DECIDE, HOLD}
  - Default width constants RAND_W_DEF=20, BETA_FRAC_DEF=8
  - Typedef `beta_t`
- One sub-module, `anneal_schedule`: beta register, step counter, restart/saturation logic. Interface: handshake strobe in, beta out.
- The decision FSM stays in the top module.

Test Plan (BETA0=256, BETA_FRAC=8, BETA_STEP=16, STEPS_PER_LEVEL=4, BETA_MAX=288, out_ready=1 unless noted):
1. delta=-5, then delta=0 → both out_accept=1, out_valid three cycles after each input handshake; rand_take=1 in DECIDE for each.
2. delta=3 (shift 3, threshold 131072): rand_in=131071 → accept; rand_in=131072 → reject.
3. delta=25 → reject for any rand_in; delta=21 with beta_out=256 → shift 21 ≥ 20 → reject.
4. 8 back-to-back decisions → beta_out reads 256 for decisions 1–4, 272 for 5–8; after decision 8 it saturates at 288 and stays there after 4 more decisions.
5. out_ready=0 for 10 cycles in HOLD → out_valid and out_accept stable, in_ready=0; release → one handshake, step counter +1 only.
6. Mid-operation checks:
   - rst low during MUL → outputs return to reset values immediately, beta=256.
   - restart pulsed with a handshake at counter=3 → beta=256, counter=0.
   - With ANNEAL_STATS_EN, accept_cnt and reject_cnt match the scoreboard.
